// File: rtl/nubus_pkg.sv
// Shared types and constants for the slot-9 bridge: FSM states, slot decode prefix,
// and the helper that maps a CPU address onto the card's 24-bit slot window.
package nubus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    HOLD,
    RECOVER
  } bridge_state_e;

  localparam logic [3:0] MINOR_SLOT_PREFIX = 4'hF;
  localparam int         SLOT_ADDR_W       = 24;

  function automatic logic [31:0] slot_addr_of(input logic [31:0] cpu_addr);
    return {{(32 - SLOT_ADDR_W){1'b0}}, cpu_addr[SLOT_ADDR_W-1:0]};
  endfunction

endpackage

// File: rtl/nubus_sync2.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to RESET_VAL.
module nubus_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nubus_slot_bridge.sv
// 68k-to-slot-card bridge: decodes slot space, runs the select/ack_n handshake,
// returns DTACK or BERR, and synchronises nmrq_n. Define NUBUS_SUPER_SLOT_EN to also decode super slot space.
module nubus_slot_bridge
  import nubus_pkg::*;
#(
  parameter logic [3:0] SLOT_ID        = 4'h9,
  parameter int         TIMEOUT_CYCLES = 256,
  parameter int         TO_W           = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  input  logic        cpu_as_n,
  input  logic        cpu_uds_n,
  input  logic        cpu_lds_n,
  input  logic        cpu_rw_n,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic [31:0] slot_addr,
  output logic [15:0] slot_wdata,
  input  logic [15:0] slot_rdata,
  output logic [1:0]  slot_uds_lds,
  output logic        slot_rw_n,
  output logic        slot_select,
  input  logic        slot_ack_n,
  input  logic        slot_nmrq_n,
  output logic        slot_irq_n
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e   state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic            select_q, select_d;
  logic            dtack_n_q, dtack_n_d;
  logic            berr_n_q, berr_n_d;
  logic [15:0]     dout_q, dout_d;
  logic [31:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      uds_lds_q, uds_lds_d;
  logic            rw_n_q, rw_n_d;

  logic minor_hit;
  logic super_hit;
  logic hit;

  assign minor_hit = (cpu_addr[31:24] == {MINOR_SLOT_PREFIX, SLOT_ID});
`ifdef NUBUS_SUPER_SLOT_EN
  assign super_hit = (cpu_addr[31:28] == SLOT_ID);
`else
  assign super_hit = 1'b0;
`endif
  assign hit = !cpu_as_n && (minor_hit || super_hit);

  // NOTE: every next-state signal takes its current value first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q | cpu_as_n;
    select_d  = select_q;
    dtack_n_d = dtack_n_q;
    berr_n_d  = berr_n_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    uds_lds_d = uds_lds_q;
    rw_n_d    = rw_n_q;

    unique case (state_q)
      IDLE: begin
        // armed_q blocks re-accepting an access whose AS never went high after the last one
        if (hit && armed_q) begin
          addr_d    = slot_addr_of(cpu_addr);
          wdata_d   = cpu_din;
          rw_n_d    = cpu_rw_n;
          uds_lds_d = {~cpu_uds_n, ~cpu_lds_n};
          select_d  = 1'b1;
          cnt_d     = '0;
          armed_d   = 1'b0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cpu_as_n) begin
          select_d = 1'b0;
          state_d  = RECOVER;
        end else if (!slot_ack_n) begin
          if (rw_n_q) dout_d = slot_rdata;
          dtack_n_d = 1'b0;
          state_d   = HOLD;
        end else if (cnt_q == TO_LAST) begin
          berr_n_d = 1'b0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cpu_as_n) begin
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
          select_d  = 1'b0;
          state_d   = RECOVER;
        end
      end
      RECOVER: begin
        if (slot_ack_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      select_q  <= 1'b0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      dout_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      uds_lds_q <= '0;
      rw_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      select_q  <= select_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      uds_lds_q <= uds_lds_d;
      rw_n_q    <= rw_n_d;
    end
  end

  assign cpu_dout     = dout_q;
  assign cpu_dtack_n  = dtack_n_q;
  assign cpu_berr_n   = berr_n_q;
  assign slot_addr    = addr_q;
  assign slot_wdata   = wdata_q;
  assign slot_uds_lds = uds_lds_q;
  assign slot_rw_n    = rw_n_q;
  assign slot_select  = select_q;

  nubus_sync2 #(
    .RESET_VAL(1'b1)
  ) u_irq_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (slot_nmrq_n),
    .q_o    (slot_irq_n)
  );

endmodule

// File: tb/tb_nubus_slot_bridge.sv
// Scoreboard bench for nubus_slot_bridge: a CPU driver pushes expected slot fields and
// terminations, a card model answers with programmable delay, and a monitor compares.
module tb_nubus_slot_bridge;

  localparam int T      = 256;
  localparam int NO_ACK = 100000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_as_n;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic        cpu_rw_n;
  logic        cpu_dtack_n;
  logic        cpu_berr_n;
  logic [31:0] slot_addr;
  logic [15:0] slot_wdata;
  logic [15:0] slot_rdata;
  logic [1:0]  slot_uds_lds;
  logic        slot_rw_n;
  logic        slot_select;
  logic        slot_ack_n;
  logic        slot_nmrq_n;
  logic        slot_irq_n;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        rw_n;
    logic [1:0]  uds_lds;
  } sel_exp_t;

  typedef struct {
    logic        berr;
    int          lat;
    logic [15:0] dout;
  } term_exp_t;

  sel_exp_t    sel_q[$];
  term_exp_t   term_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] model_dout;
  int          card_delay;
  int          card_hold;
  logic [15:0] card_rdata;

  nubus_slot_bridge dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_dout    (cpu_dout),
    .cpu_as_n    (cpu_as_n),
    .cpu_uds_n   (cpu_uds_n),
    .cpu_lds_n   (cpu_lds_n),
    .cpu_rw_n    (cpu_rw_n),
    .cpu_dtack_n (cpu_dtack_n),
    .cpu_berr_n  (cpu_berr_n),
    .slot_addr   (slot_addr),
    .slot_wdata  (slot_wdata),
    .slot_rdata  (slot_rdata),
    .slot_uds_lds(slot_uds_lds),
    .slot_rw_n   (slot_rw_n),
    .slot_select (slot_select),
    .slot_ack_n  (slot_ack_n),
    .slot_nmrq_n (slot_nmrq_n),
    .slot_irq_n  (slot_irq_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot 9 minor space is the 16 MB range $F9000000..$F9FFFFFF; super space is $9xxxxxxx.
  function automatic bit model_hit(input logic [31:0] a);
    bit h;
    h = (a >= 32'hF900_0000) && (a <= 32'hF9FF_FFFF);
`ifdef NUBUS_SUPER_SLOT_EN
    h = h || ((a >= 32'h9000_0000) && (a <= 32'h9FFF_FFFF));
`endif
    return h;
  endfunction

  // Card: acks card_delay clocks after seeing select, holds ack until select drops plus card_hold clocks.
  initial begin
    int d;
    int h;
    slot_ack_n = 1'b1;
    slot_rdata = '0;
    forever begin
      @(negedge clk);
      if (slot_select === 1'b1) begin
        d = card_delay;
        h = card_hold;
        slot_rdata = card_rdata;
        if (d >= NO_ACK) begin
          while (slot_select === 1'b1) @(negedge clk);
        end else begin
          repeat (d) @(posedge clk);
          #1 slot_ack_n = 1'b0;
          while (slot_select === 1'b1) @(negedge clk);
          repeat (h) @(posedge clk);
          #1 slot_ack_n = 1'b1;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever select rises or dtack/berr falls.
  logic      p_sel = 1'b0;
  logic      p_dt  = 1'b1;
  logic      p_be  = 1'b1;
  int        sel_t = 0;
  sel_exp_t  mon_s;
  term_exp_t mon_t;

  initial begin
    forever begin
      @(negedge clk);
      if (slot_select && !p_sel) begin
        sel_t = cyc;
        check("accept_while_ack_low", slot_ack_n, 1);
        check("select_expected", sel_q.size() != 0, 1);
        if (sel_q.size() != 0) begin
          mon_s = sel_q.pop_front();
          check("slot_addr", slot_addr, mon_s.addr);
          check("slot_wdata", slot_wdata, mon_s.wdata);
          check("slot_rw_n", slot_rw_n, mon_s.rw_n);
          check("slot_uds_lds", slot_uds_lds, mon_s.uds_lds);
        end
      end
      if ((!cpu_dtack_n && p_dt) || (!cpu_berr_n && p_be)) begin
        check("term_expected", term_q.size() != 0, 1);
        if (term_q.size() != 0) begin
          mon_t = term_q.pop_front();
          check("term_kind", {~cpu_dtack_n, ~cpu_berr_n}, mon_t.berr ? 2'b01 : 2'b10);
          check("term_latency", cyc - sel_t, mon_t.lat);
          check("cpu_dout", cpu_dout, mon_t.dout);
        end
      end
      p_sel = slot_select;
      p_dt  = cpu_dtack_n;
      p_be  = cpu_berr_n;
    end
  end

  task automatic wait_select();
    int n;
    n = 0;
    @(negedge clk);
    while (slot_select !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("select_seen", slot_select, 1);
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [15:0] din, input logic rw_n,
                        input logic uds_n, input logic lds_n, input int d,
                        input logic [15:0] rd, input int h, input int abort_a);
    bit        hit;
    sel_exp_t  s;
    term_exp_t e;
    int        n;
    int        extra;
    hit        = model_hit(a);
    card_delay = d;
    card_rdata = rd;
    card_hold  = h;
    @(posedge clk);
    #1;
    cpu_addr  = a;
    cpu_din   = din;
    cpu_rw_n  = rw_n;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    cpu_as_n  = 1'b0;
    if (!hit) begin
      repeat (4) @(negedge clk);
      check("miss_select", slot_select, 0);
      check("miss_dtack_n", cpu_dtack_n, 1);
      check("miss_berr_n", cpu_berr_n, 1);
      @(posedge clk);
      #1 cpu_as_n = 1'b1;
      return;
    end
    s.addr    = a % 32'h0100_0000;
    s.wdata   = din;
    s.rw_n    = rw_n;
    s.uds_lds = {~uds_n, ~lds_n};
    sel_q.push_back(s);
    if (abort_a >= 0) begin
      wait_select();
      repeat (abort_a) @(posedge clk);
      #1 cpu_as_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_select", slot_select, 0);
      check("abort_dtack_n", cpu_dtack_n, 1);
      check("abort_berr_n", cpu_berr_n, 1);
      n = 0;
      while (slot_ack_n && n < 16) begin
        @(negedge clk);
        n++;
      end
      check("abort_late_ack", slot_ack_n, 0);
      return;
    end
    if (d < NO_ACK && d + 1 <= T) begin
      e.berr = 1'b0;
      e.lat  = d + 1;
      if (rw_n) model_dout = rd;
    end else begin
      e.berr = 1'b1;
      e.lat  = T;
    end
    e.dout = model_dout;
    term_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (cpu_dtack_n && cpu_berr_n && n < T + 64) begin
      @(negedge clk);
      n++;
    end
    check("term_seen", !(cpu_dtack_n && cpu_berr_n), 1);
    extra = $urandom_range(1, 2);
    repeat (extra) begin
      @(negedge clk);
      check("hold_dtack_n", cpu_dtack_n, e.berr);
      check("hold_berr_n", cpu_berr_n, !e.berr);
      check("hold_select", slot_select, 1);
    end
    @(posedge clk);
    #1 cpu_as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_dtack_n", cpu_dtack_n, 1);
    check("release_berr_n", cpu_berr_n, 1);
    check("release_select", slot_select, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          cls;
    int          d;
    int          ab;
    int          h;
    int          sl;
    int          st;
    reset_n     = 1'b0;
    cpu_addr    = '0;
    cpu_din     = '0;
    cpu_as_n    = 1'b1;
    cpu_uds_n   = 1'b1;
    cpu_lds_n   = 1'b1;
    cpu_rw_n    = 1'b1;
    slot_nmrq_n = 1'b1;
    card_delay  = 1;
    card_hold   = 0;
    card_rdata  = '0;
    model_dout  = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_dtack_n", cpu_dtack_n, 1);
    check("rst_berr_n", cpu_berr_n, 1);
    check("rst_select", slot_select, 0);
    check("rst_irq_n", slot_irq_n, 1);
    check("rst_dout", cpu_dout, 0);
    check("rst_slot_addr", slot_addr, 0);
    check("rst_slot_wdata", slot_wdata, 0);
    check("rst_uds_lds", slot_uds_lds, 0);
    check("rst_rw_n", slot_rw_n, 1);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    do_txn(32'hF908_0008, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 16'h0300, 1, -1);
    do_txn(32'hF900_0010, 16'hA55A, 1'b0, 1'b0, 1'b1, 1, 16'h1234, 0, -1);
    do_txn(32'hF910_0000, 16'h0000, 1'b1, 1'b0, 1'b0, NO_ACK, 16'h0000, 0, -1);
    do_txn(32'hFA00_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h0000, 0, -1);
    do_txn(32'h9000_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h0BAD, 0, -1);
    do_txn(32'h9000_0004, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h4444, 0, -1);
    do_txn(32'hF900_0100, 16'h0000, 1'b1, 1'b0, 1'b0, 6, 16'hDEAD, 2, 1);
    do_txn(32'hF900_0200, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h1111, 0, -1);
    do_txn(32'hF900_0202, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 16'h2222, 0, -1);
    do_txn(32'hF9AB_CDEF, 16'h0000, 1'b1, 1'b0, 1'b0, T - 1, 16'h7777, 1, -1);
    do_txn(32'hF9AB_CDF0, 16'h0000, 1'b1, 1'b0, 1'b0, T, 16'h8888, 1, -1);

    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 5) begin
        a = {8'hF9, 24'($urandom)};
      end else if (cls == 6) begin
        a = {4'h9, 28'($urandom)};
      end else if (cls == 7) begin
        sl = $urandom_range(0, 15);
        if (sl == 9) sl = 3;
        a = {4'hF, 4'(sl), 24'($urandom)};
      end else begin
        a = $urandom;
      end
      d  = ($urandom_range(0, 19) == 0) ? NO_ACK : $urandom_range(1, 8);
      ab = -1;
      if (d < NO_ACK && $urandom_range(0, 4) == 0) begin
        if (d < 2) d = 2;
        ab = $urandom_range(0, d - 1);
      end
      h  = (ab >= 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      st = $urandom_range(0, 2);
      do_txn(a, 16'($urandom), 1'($urandom), st == 2, st == 1, d, 16'($urandom), h, ab);
    end

    card_delay = NO_ACK;
    card_hold  = 0;
    @(posedge clk);
    #1;
    cpu_addr  = 32'hF900_0020;
    cpu_rw_n  = 1'b1;
    cpu_uds_n = 1'b0;
    cpu_lds_n = 1'b0;
    cpu_as_n  = 1'b0;
    begin
      sel_exp_t s;
      s.addr    = 32'h0000_0020;
      s.wdata   = cpu_din;
      s.rw_n    = 1'b1;
      s.uds_lds = 2'b11;
      sel_q.push_back(s);
    end
    wait_select();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_select", slot_select, 0);
    check("midrst_dtack_n", cpu_dtack_n, 1);
    check("midrst_berr_n", cpu_berr_n, 1);
    check("midrst_dout", cpu_dout, 0);
    check("midrst_slot_addr", slot_addr, 0);
    check("midrst_rw_n", slot_rw_n, 1);
    model_dout = '0;
    cpu_as_n   = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    do_txn(32'hF900_0030, 16'h5A5A, 1'b0, 1'b0, 1'b0, 3, 16'hFFFF, 0, -1);

    @(posedge clk);
    #1 slot_nmrq_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      if (k == 5) #1 slot_nmrq_n = 1'b1;
      @(negedge clk);
      check($sformatf("irq_k%0d", k), slot_irq_n, (k >= 2 && k <= 6) ? 0 : 1);
    end

    repeat (4) @(posedge clk);
    check("sel_queue_drained", sel_q.size(), 0);
    check("term_queue_drained", term_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nubus_slot_bridge.md
Name: nubus_slot_bridge

Overview:
- Sits between the 68k CPU bus and the slot-9 video card: decodes CPU accesses to the card's slot space and turns them into the card's select/ack_n slot handshake.
- Returns read data with DTACK, or BERR when the card does not respond in time.
- Synchronises the card's nmrq_n into an active-low slot interrupt for VIA2.

Parameters:
- SLOT_ID, 4'h9, slot number s; minor slot space is $Fs000000-$FsFFFFFF.
- TIMEOUT_CYCLES, 256, clk cycles from select assertion to BERR if ack_n stays high.
- TO_W, 9, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  32  CPU address
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  read data to CPU, registered
- cpu_as_n  in  1  address strobe, synchronous to clk
- cpu_uds_n  in  1  upper data strobe
- cpu_lds_n  in  1  lower data strobe
- cpu_rw_n  in  1  1 = read
- cpu_dtack_n  out  1  transfer acknowledge
- cpu_berr_n  out  1  bus error
- slot_addr  out  32  to card addr
- slot_wdata  out  16  to card data_in
- slot_rdata  in  16  from card data_out
- slot_uds_lds  out  2  to card uds_lds; bit1 = upper byte
- slot_rw_n  out  1  to card rw_n
- slot_select  out  1  to card select
- slot_ack_n  in  1  from card ack_n
- slot_nmrq_n  in  1  from card nmrq_n
- slot_irq_n  out  1  synchronised slot interrupt to VIA2

Behaviour:
- Reset values:
  - cpu_dtack_n = 1, cpu_berr_n = 1, slot_select = 0, slot_irq_n = 1.
  - cpu_dout = 0, slot_addr = 0, slot_wdata = 0, slot_uds_lds = 0, slot_rw_n = 1.
  - state = IDLE, timeout counter = 0.
- Decode hit: cpu_as_n = 0 and cpu_addr[31:24] == {4'hF, SLOT_ID}. The bridge ignores every miss; it never drives dtack or berr for a miss.
- State IDLE, on a hit:
  - Latch slot_addr = {8'h00, cpu_addr[23:0]}, slot_wdata = cpu_din, slot_rw_n = cpu_rw_n, slot_uds_lds = {~cpu_uds_n, ~cpu_lds_n}.
  - Assert slot_select.
  - Clear the counter and go to WAIT_ACK.
  - Latched fields stay constant until the next IDLE.
- State WAIT_ACK:
  - slot_ack_n sampled 0: capture cpu_dout = slot_rdata (reads only; writes leave cpu_dout unchanged), drive cpu_dtack_n = 0 next cycle, go to HOLD.
  - Counter reaches TIMEOUT_CYCLES-1 with ack_n still 1: drive cpu_berr_n = 0, go to HOLD.
  - cpu_as_n goes 1 (CPU abort): drop slot_select, go to RECOVER; neither dtack nor berr is asserted.
  - If ack and timeout fall in the same cycle, ack wins.
- State HOLD:
  - Keep slot_select = 1 and hold dtack/berr until cpu_as_n = 1.
  - Then release dtack and berr (both 1), drop slot_select, go to RECOVER.
- State RECOVER:
  - Wait for slot_ack_n = 1, then go to IDLE.
  - A new hit is never accepted while the card's ack_n is still low.
  - A hit with AS still low from the previous cycle is not re-accepted: IDLE requires cpu_as_n to have been observed high since the last transaction.
- Latency: a card acking in 1 cycle gives dtack 3 clk after AS falls.
- Interrupt path:
  - slot_nmrq_n passes through a 2-flop synchroniser to slot_irq_n; level, not edge.
  - Both flops reset to 1.
  - Clearing is the card's job (register write at $08_0004).
- Reset asserted mid-transaction forces reset values immediately, asynchronously; the card sees select fall.

Optional Feature:
- NUBUS_SUPER_SLOT_EN:
  - Defined: the decode also hits on cpu_addr[31:28] == SLOT_ID (super slot space $s0000000-$sFFFFFFF). The slot address is formed identically from cpu_addr[23:0], so only the low 16 MB of super space is reachable (it aliases).
  - Undefined: minor slot space only; super-space accesses are misses.

Decomposition:
- Package nubus_pkg:
  - bridge state enum (IDLE, WAIT_ACK, HOLD, RECOVER)
  - constant MINOR_SLOT_PREFIX = 4'hF
  - constant SLOT_ADDR_W = 24
- One sub-module: nubus_sync2, a two-flop synchroniser with parameterised reset value, used for slot_nmrq_n.

Test Plan:
- Read $F9080008 with the card model acking after 2 cycles and slot_rdata = 16'h0300 -> slot_addr = 32'h00080008, slot_rw_n = 1; cpu_dout = 16'h0300; cpu_dtack_n low until AS rises; select drops after AS rises.
- Write $F9000010 = 16'hA55A with only UDS low -> slot_uds_lds = 2'b10, slot_wdata = 16'hA55A, dtack asserted; cpu_dout unchanged.
- Access $F9100000 with the card never acking -> cpu_berr_n = 0 exactly TIMEOUT_CYCLES cycles after select; dtack stays 1.
- Access $FA000000 and $90000000 -> no select, no dtack, no berr. With NUBUS_SUPER_SLOT_EN, $90000004 -> slot_addr = 32'h00000004.
- CPU raises AS in WAIT_ACK before the ack arrives -> select drops next cycle, no dtack, FSM waits in RECOVER until ack_n = 1. Back-to-back reads each complete.
- slot_nmrq_n pulses low for 5 cycles -> slot_irq_n low for 5 cycles, delayed by 2 cycles. Asserting reset_n mid-read -> dtack/berr/select return to reset values without a clock edge.
